// File: rtl/rob_multi_wb_pkg.sv
// Shared types, op encodings and helpers for the multi-writeback reorder buffer.
package rob_multi_wb_pkg;

    localparam int DEF_ROB_DEPTH = 16;
    localparam int DEF_ROB_IDX_W = $clog2(DEF_ROB_DEPTH);
    localparam int DEF_NUM_WB    = 2;
    localparam int DEF_REG_ID_W  = 5;

    typedef logic [5:0] op_t;

    localparam op_t OP_JALR     = 6'd3;
    localparam op_t OP_BR_FIRST = 6'd4;
    localparam op_t OP_BR_LAST  = 6'd7;
    localparam op_t OP_ST_FIRST = 6'd15;
    localparam op_t OP_ST_LAST  = 6'd17;
    localparam op_t OP_EXIT     = 6'd39;

    typedef enum logic [2:0] {
        RK_ALU,
        RK_BRANCH,
        RK_JALR,
        RK_STORE,
        RK_EXIT
    } ret_kind_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
    } rob_meta_t;

    function automatic logic is_branch(op_t op);
        return (op >= OP_BR_FIRST) && (op <= OP_BR_LAST);
    endfunction

    function automatic logic is_store(op_t op);
        return (op >= OP_ST_FIRST) && (op <= OP_ST_LAST);
    endfunction

    function automatic ret_kind_t ret_kind(op_t op);
        ret_kind_t k;
        unique case (1'b1)
            is_branch(op):   k = RK_BRANCH;
            is_store(op):    k = RK_STORE;
            (op == OP_JALR): k = RK_JALR;
            (op == OP_EXIT): k = RK_EXIT;
            default:         k = RK_ALU;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Folds the writeback channels into per-entry write strobes and data.
// Lower channel numbers win when two channels name the same entry.
module rob_wb_merge #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int NUM_WB = 2
) (
    input  logic [NUM_WB-1:0]       wb_valid,
    input  logic [NUM_WB*IDX_W-1:0] wb_id,
    input  logic [NUM_WB*32-1:0]    wb_value,
    input  logic [NUM_WB*32-1:0]    wb_target,
    output logic [DEPTH-1:0]        ent_we,
    output logic [31:0]             ent_value  [DEPTH],
    output logic [31:0]             ent_target [DEPTH]
);

    always_comb begin
        ent_we = '0;
        for (int e = 0; e < DEPTH; e++) begin
            ent_value[e]  = '0;
            ent_target[e] = '0;
        end
        // Walk from the highest channel down so channel 0 lands last.
        for (int c = NUM_WB - 1; c >= 0; c--) begin
            if (wb_valid[c]) begin
                ent_we[wb_id[c*IDX_W +: IDX_W]]     = 1'b1;
                ent_value[wb_id[c*IDX_W +: IDX_W]]  = wb_value[c*32 +: 32];
                ent_target[wb_id[c*IDX_W +: IDX_W]] = wb_target[c*32 +: 32];
            end
        end
    end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer: one in-order issue, NUM_WB out-of-order writebacks,
// one in-order retire per cycle with branch/JALR/store/exit handling.
module rob_multi_wb
    import rob_multi_wb_pkg::*;
#(
    parameter int ROB_DEPTH = DEF_ROB_DEPTH,
    parameter int ROB_IDX_W = $clog2(ROB_DEPTH),
    parameter int NUM_WB    = DEF_NUM_WB,
    parameter int REG_ID_W  = DEF_REG_ID_W
) (
    input  logic                        clk_in,
    input  logic                        rst_in_n,
    input  logic                        rdy_in,
    input  logic                        issue_valid,
    input  logic [5:0]                  issue_op,
    input  logic [REG_ID_W-1:0]         issue_rd,
    input  logic [31:0]                 issue_pc,
    input  logic [31:0]                 issue_imm,
    input  logic                        issue_pred,
    output logic                        issue_ready,
    output logic [ROB_IDX_W-1:0]        issue_id,
    input  logic [ROB_IDX_W-1:0]        q1_id,
    input  logic [ROB_IDX_W-1:0]        q2_id,
    output logic                        q1_ready,
    output logic                        q2_ready,
    output logic [31:0]                 q1_value,
    output logic [31:0]                 q2_value,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*ROB_IDX_W-1:0] wb_id,
    input  logic [NUM_WB*32-1:0]        wb_value,
    input  logic [NUM_WB*32-1:0]        wb_target,
    output logic [ROB_IDX_W-1:0]        head_id,
    output logic                        commit_valid,
    output logic [REG_ID_W-1:0]         commit_rd,
    output logic [ROB_IDX_W-1:0]        commit_id,
    output logic [31:0]                 commit_value,
    output logic                        store_req,
    output logic [ROB_IDX_W-1:0]        store_id,
    input  logic                        store_ack,
    output logic                        bp_update,
    output logic [31:0]                 bp_pc,
    output logic                        bp_taken,
    output logic                        flush,
    output logic                        redirect_valid,
    output logic [31:0]                 redirect_pc,
    output logic                        halt
);

    localparam int CNT_W = ROB_IDX_W + 1;

    logic [ROB_DEPTH-1:0] busy;
    logic [ROB_DEPTH-1:0] done;
    rob_meta_t            meta_q [ROB_DEPTH];
    logic [REG_ID_W-1:0]  rd_q   [ROB_DEPTH];
    logic [31:0]          val_q  [ROB_DEPTH];
    logic [31:0]          tgt_q  [ROB_DEPTH];
    logic [ROB_IDX_W-1:0] head;
    logic [ROB_IDX_W-1:0] tail;
    logic [CNT_W-1:0]     count;

    logic [ROB_DEPTH-1:0] wb_we;
    logic [31:0]          wb_val [ROB_DEPTH];
    logic [31:0]          wb_tgt [ROB_DEPTH];

    rob_wb_merge #(
        .DEPTH  (ROB_DEPTH),
        .IDX_W  (ROB_IDX_W),
        .NUM_WB (NUM_WB)
    ) u_merge (
        .wb_valid   (wb_valid),
        .wb_id      (wb_id),
        .wb_value   (wb_value),
        .wb_target  (wb_target),
        .ent_we     (wb_we),
        .ent_value  (wb_val),
        .ent_target (wb_tgt)
    );

    rob_meta_t   h_meta;
    logic [31:0] h_val;
    ret_kind_t   h_kind;
    logic        h_ok;
    logic        h_mispred;
    logic        retire;
    logic        issue_fire;

    assign issue_ready = (count < CNT_W'(ROB_DEPTH));
    assign issue_id    = tail;
    assign head_id     = head;
    assign store_id    = head;

    always_comb begin
        h_meta     = meta_q[head];
        h_val      = val_q[head];
        h_kind     = ret_kind(h_meta.op);
        h_ok       = busy[head] & done[head];
        h_mispred  = (h_val[0] != h_meta.pred);
        store_req  = h_ok & (h_kind == RK_STORE) & ~flush & ~halt;
        retire     = rdy_in & ~flush & ~halt & h_ok &
                     ((h_kind != RK_STORE) | store_ack);
        issue_fire = rdy_in & issue_valid & issue_ready & ~flush & ~halt;
    end

    // Operand lookup sees a same-cycle writeback before it lands.
    always_comb begin
        q1_ready = wb_we[q1_id] | done[q1_id] | ~busy[q1_id];
        q1_value = wb_we[q1_id] ? wb_val[q1_id] :
                   (q1_ready ? val_q[q1_id] : 32'd0);
        q2_ready = wb_we[q2_id] | done[q2_id] | ~busy[q2_id];
        q2_value = wb_we[q2_id] ? wb_val[q2_id] :
                   (q2_ready ? val_q[q2_id] : 32'd0);
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= '0;
            done  <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                meta_q[i] <= '0;
                rd_q[i]   <= '0;
                val_q[i]  <= '0;
                tgt_q[i]  <= '0;
            end
            commit_valid   <= 1'b0;
            commit_rd      <= '0;
            commit_id      <= '0;
            commit_value   <= '0;
            bp_update      <= 1'b0;
            bp_pc          <= '0;
            bp_taken       <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            halt           <= 1'b0;
        end else begin
            commit_valid   <= 1'b0;
            bp_update      <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            if (rdy_in) begin
                for (int i = 0; i < ROB_DEPTH; i++) begin
                    if (wb_we[i] && busy[i] && !flush) begin
                        done[i]  <= 1'b1;
                        val_q[i] <= wb_val[i];
                        tgt_q[i] <= wb_tgt[i];
                    end
                end
                if (issue_fire) begin
                    busy[tail]   <= 1'b1;
                    done[tail]   <= 1'b0;
                    meta_q[tail] <= '{op: issue_op, pc: issue_pc,
                                      imm: issue_imm, pred: issue_pred};
                    rd_q[tail]   <= issue_rd;
                    tail         <= tail + 1'b1;
                end
                if (retire) begin
                    busy[head]   <= 1'b0;
                    head         <= head + 1'b1;
                    commit_valid <= 1'b1;
                    commit_id    <= head;
                    commit_value <= h_val;
                    commit_rd    <= (h_kind == RK_BRANCH || h_kind == RK_STORE)
                                    ? '0 : rd_q[head];
                    case (h_kind)
                        RK_BRANCH: begin
                            bp_update <= 1'b1;
                            bp_pc     <= h_meta.pc;
                            bp_taken  <= h_val[0];
                            if (h_mispred) begin
                                flush          <= 1'b1;
                                redirect_valid <= 1'b1;
                                redirect_pc    <= h_val[0]
                                    ? h_meta.pc + h_meta.imm
                                    : h_meta.pc + 32'd4;
                            end
                        end
                        RK_JALR: begin
                            redirect_valid <= 1'b1;
                            redirect_pc    <= tgt_q[head];
                        end
                        RK_EXIT: halt <= 1'b1;
                        default: ;
                    endcase
                end
                case ({issue_fire, retire})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
                // A mispredict drops every younger entry and this cycle's issue.
                if (retire && h_kind == RK_BRANCH && h_mispred) begin
                    head  <= '0;
                    tail  <= '0;
                    count <= '0;
                    busy  <= '0;
                    done  <= '0;
                end
            end
        end
    end

endmodule
